// File: rtl/signed_mult_ctrl.sv
// signed_mult_ctrl: multi-cycle signed multiply sequencer for the 8-bit core.
// Phases: sign-magnitude conversion (NEG), iterative shift-add (MUL),
// product sign correction (FIX), then a one-cycle DONE pulse.
// Optional macro SIGNED_MULT_EARLY_TERM_EN: leave MUL as soon as the remaining
// multiplier magnitude is zero (variable latency, identical results).
module signed_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [WIDTH-1:0]     MULTIPLICAND,
    input  logic [WIDTH-1:0]     MULTIPLIER,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 OVF
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG,
        S_MUL,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_p0, b_p0;
    logic                    sign_p0;
    logic [WIDTH-1:0]        amag_p1, bmag_p1;
    logic [PW-1:0]           acc_p2;
    logic [CW-1:0]           cnt;
    logic                    last_iter;
    logic                    skip;
    logic [WIDTH:0]          sum_p2;
    logic [PW-1:0]           acc_fin;
    logic [PW-1:0]           prod_fix;

    // Magnitude of a two's-complement operand; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] u;
        u = x;
        return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    // Re-apply the product sign; negating zero stays zero.
    function automatic logic [PW-1:0] apply_sign(input logic neg, input logic [PW-1:0] m);
        return neg ? (~m + PW'(1)) : m;
    endfunction

    // Product does not fit a signed WIDTH-bit value unless its top WIDTH+1 bits agree.
    function automatic logic ovf_of(input logic [PW-1:0] p);
        logic [WIDTH:0] top;
        top = p[PW-1:WIDTH-1];
        return (top != '0) && (top != '1);
    endfunction

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: if (START) state_nxt = S_NEG;
            S_NEG: begin
                BUSY      = 1'b1;
                state_nxt = S_MUL;
            end
            S_MUL: begin
                BUSY = 1'b1;
                if (skip || last_iter) state_nxt = S_FIX;
            end
            S_FIX: begin
                BUSY      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = START ? S_NEG : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared adder, early-exit test, final alignment and sign correction
    always_comb begin
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef SIGNED_MULT_EARLY_TERM_EN
        // Each skipped iteration would only have shifted right once more.
        skip    = (bmag_p1 == '0);
        acc_fin = acc_p2 >> (CW'(WIDTH) - cnt);
`else
        skip    = 1'b0;
        acc_fin = acc_p2;
`endif
        sum_p2   = {1'b0, acc_p2[PW-1:WIDTH]} + (bmag_p1[0] ? {1'b0, amag_p1} : '0);
        prod_fix = apply_sign(sign_p0, acc_fin);
    end

    // Operand capture, magnitude, accumulator and result registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            a_p0    <= '0;
            b_p0    <= '0;
            sign_p0 <= 1'b0;
            amag_p1 <= '0;
            bmag_p1 <= '0;
            acc_p2  <= '0;
            cnt     <= '0;
            PRODUCT <= '0;
            OVF     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        a_p0    <= MULTIPLICAND;
                        b_p0    <= MULTIPLIER;
                        sign_p0 <= MULTIPLICAND[WIDTH-1] ^ MULTIPLIER[WIDTH-1];
                    end
                end
                S_NEG: begin
                    amag_p1 <= mag_of(a_p0);
                    bmag_p1 <= mag_of(b_p0);
                    acc_p2  <= '0;
                    cnt     <= '0;
                end
                S_MUL: begin
                    if (!skip) begin
                        acc_p2  <= {sum_p2, acc_p2[WIDTH-1:1]};
                        bmag_p1 <= bmag_p1 >> 1;
                        cnt     <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    PRODUCT <= prod_fix;
                    OVF     <= ovf_of(prod_fix);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Testbench for signed_mult_ctrl: directed and random operands against an
// arithmetic reference model (integer multiply, range test, latency rule).
module tb_signed_mult_ctrl;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [7:0]  MULTIPLICAND;
    logic [7:0]  MULTIPLIER;
    logic        BUSY;
    logic        DONE;
    logic [15:0] PRODUCT;
    logic        OVF;

    int checks;
    int failures;

    signed_mult_ctrl #(.WIDTH(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .MULTIPLICAND(MULTIPLICAND),
        .MULTIPLIER(MULTIPLIER),
        .BUSY(BUSY),
        .DONE(DONE),
        .PRODUCT(PRODUCT),
        .OVF(OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, r;
        pa = int'($signed(a));
        pb = int'($signed(b));
        r  = pa * pb;
        return r[15:0];
    endfunction

    function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = int'($signed(a)) * int'($signed(b));
        return (r < -128) || (r > 127);
    endfunction

    // Edges from the accepting edge to the edge after which DONE is high.
    function automatic int model_lat(input logic [7:0] b);
`ifdef SIGNED_MULT_EARLY_TERM_EN
        int m, k;
        m = int'($signed(b));
        if (m < 0) m = -m;
        k = 0;
        while (m != 0) begin
            k = k + 1;
            m = m / 2;
        end
        return (k < 8) ? (3 + k) : 10;
`else
        return 10;
`endif
    endfunction

    // Drives one multiply and observes it; comparisons are made by the callers.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, output int lat,
                           output logic [15:0] p, output logic o, output logic busy_ok);
        @(negedge CLK);
        MULTIPLICAND = a;
        MULTIPLIER   = b;
        START        = 1'b1;
        @(posedge CLK);
        #1;
        START        = 1'b0;
        MULTIPLICAND = 8'($urandom);
        MULTIPLIER   = 8'($urandom);
        busy_ok = (BUSY === 1'b1) && (DONE === 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) begin
                lat = i;
                busy_ok = busy_ok && (BUSY === 1'b0);
                break;
            end
            busy_ok = busy_ok && (BUSY === 1'b1);
        end
        p = PRODUCT;
        o = OVF;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RESET = 1'b0;
        START = 1'b0;
        MULTIPLICAND = 8'h00;
        MULTIPLIER   = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if (PRODUCT !== 16'h0000) begin failures++; $display("FAIL reset_product: got %h expected 0000", PRODUCT); end
        checks++; if (OVF !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] av [12];
        logic [7:0] bv [12];
        int lat;
        logic [15:0] p, exp_p;
        logic o, bok;
        av = '{8'd5, 8'hF9, 8'h80, 8'd16, 8'd16, 8'd9, 8'd9, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'd3};
        bv = '{8'd3, 8'd6,  8'h80, 8'hF8, 8'd8,  8'd0, 8'd1, 8'h80, 8'h7F, 8'h7F, 8'hFF, 8'h00};
        for (int i = 0; i < 12; i++) begin
            exp_p = model_prod(av[i], bv[i]);
            run_mul(av[i], bv[i], lat, p, o, bok);
            checks++; if (lat !== model_lat(bv[i])) begin failures++; $display("FAIL dir_latency a=%h b=%h: got %0d expected %0d", av[i], bv[i], lat, model_lat(bv[i])); end
            checks++; if (p !== exp_p) begin failures++; $display("FAIL dir_product a=%h b=%h: got %h expected %h", av[i], bv[i], p, exp_p); end
            checks++; if (o !== model_ovf(av[i], bv[i])) begin failures++; $display("FAIL dir_ovf a=%h b=%h: got %b expected %b", av[i], bv[i], o, model_ovf(av[i], bv[i])); end
            checks++; if (bok !== 1'b1) begin failures++; $display("FAIL dir_busy a=%h b=%h: got %b expected 1", av[i], bv[i], bok); end
            // DONE is a single-cycle pulse and the result holds afterwards
            @(posedge CLK);
            #1;
            checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL dir_done_pulse: got %b expected 0", DONE); end
            checks++; if (PRODUCT !== exp_p) begin failures++; $display("FAIL dir_hold: got %h expected %h", PRODUCT, exp_p); end
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        int lat;
        logic [15:0] p;
        logic o, bok;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 6 == 0) b = 8'($urandom_range(0, 3));
            run_mul(a, b, lat, p, o, bok);
            checks++; if (lat !== model_lat(b)) begin failures++; $display("FAIL rnd_latency a=%h b=%h: got %0d expected %0d", a, b, lat, model_lat(b)); end
            checks++; if (p !== model_prod(a, b)) begin failures++; $display("FAIL rnd_product a=%h b=%h: got %h expected %h", a, b, p, model_prod(a, b)); end
            checks++; if (o !== model_ovf(a, b)) begin failures++; $display("FAIL rnd_ovf a=%h b=%h: got %b expected %b", a, b, o, model_ovf(a, b)); end
            checks++; if (bok !== 1'b1) begin failures++; $display("FAIL rnd_busy a=%h b=%h: got %b expected 1", a, b, bok); end
        end
    endtask

    task automatic test_ignore_start;
        int e, lat;
        @(negedge CLK);
        MULTIPLICAND = 8'd5;
        MULTIPLIER   = 8'd3;
        START        = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        // request a different multiply while busy
        @(negedge CLK);
        MULTIPLICAND = 8'd2;
        MULTIPLIER   = 8'd2;
        START        = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL ign_busy: got %b expected 1", BUSY); end
        START = 1'b0;
        e = 3;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (DONE === 1'b1) begin
                lat = e;
                break;
            end
            @(posedge CLK);
            #1;
            e++;
        end
        checks++; if (lat !== model_lat(8'd3)) begin failures++; $display("FAIL ign_latency: got %0d expected %0d", lat, model_lat(8'd3)); end
        checks++; if (PRODUCT !== model_prod(8'd5, 8'd3)) begin failures++; $display("FAIL ign_product: got %h expected %h", PRODUCT, model_prod(8'd5, 8'd3)); end
        @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ign_no_queue: got busy %b expected 0", BUSY); end
    endtask

    task automatic test_back_to_back;
        int lat, lat2;
        logic [15:0] p;
        logic o, bok;
        run_mul(8'd5, 8'd3, lat, p, o, bok);
        checks++; if (p !== model_prod(8'd5, 8'd3)) begin failures++; $display("FAIL b2b_first: got %h expected %h", p, model_prod(8'd5, 8'd3)); end
        // still in the DONE cycle: request the next multiply
        MULTIPLICAND = 8'hF9;
        MULTIPLIER   = 8'd6;
        START        = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL b2b_done_fall: got %b expected 0", DONE); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy %b expected 1", BUSY); end
        lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) begin
                lat2 = i;
                break;
            end
        end
        checks++; if (lat2 !== model_lat(8'd6)) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat2, model_lat(8'd6)); end
        checks++; if (PRODUCT !== model_prod(8'hF9, 8'd6)) begin failures++; $display("FAIL b2b_product: got %h expected %h", PRODUCT, model_prod(8'hF9, 8'd6)); end
        checks++; if (OVF !== model_ovf(8'hF9, 8'd6)) begin failures++; $display("FAIL b2b_ovf: got %b expected %b", OVF, model_ovf(8'hF9, 8'd6)); end
    endtask

    task automatic test_reset_abort;
        logic seen;
        @(negedge CLK);
        MULTIPLICAND = 8'h80;
        MULTIPLIER   = 8'h80;
        START        = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", DONE); end
        checks++; if (PRODUCT !== 16'h0000) begin failures++; $display("FAIL abort_product: got %h expected 0000", PRODUCT); end
        checks++; if (OVF !== 1'b0) begin failures++; $display("FAIL abort_ovf: got %b expected 0", OVF); end
        @(negedge CLK);
        RESET = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1 || BUSY === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done: got activity %b expected 0", seen); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        START    = 1'b0;
        MULTIPLICAND = 8'h00;
        MULTIPLIER   = 8'h00;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_mult_ctrl.md
Name: signed_mult_ctrl

Overview:
Multi-cycle sequencer that lets the 8-bit single-cycle processor perform signed multiplication using one shared adder and one shared two's-complement negation stage. It takes a start pulse and two signed operands, then steps the datapath through the phases below:
- operand sign-magnitude conversion
- iterative shift-add
- product sign correction

It raises BUSY to stall the PC/register-file write path, and pulses DONE with the 16-bit signed product.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  synchronous, active-low reset; sampled on CLK rising edge.
START  input  1  request to begin a multiply; accepted only in IDLE or DONE state.
MULTIPLICAND  input  WIDTH  signed two's-complement operand A; captured on the accepting edge.
MULTIPLIER  input  WIDTH  signed two's-complement operand B; captured on the accepting edge.
BUSY  output  1  high in NEG, MUL and FIX states; drives processor stall.
DONE  output  1  high for exactly one cycle (DONE state) when PRODUCT becomes valid.
PRODUCT  output  2*WIDTH  signed product; holds its value until the next accepted START.
OVF  output  1  set with DONE if PRODUCT is not representable as a signed WIDTH-bit value; held like PRODUCT.

Behaviour:
- Reset (RESET==0 at edge): state=IDLE, BUSY=0, DONE=0, PRODUCT=0, OVF=0, counter=0, internal registers=0.
  - Applies from any state; an in-flight multiply is aborted with no DONE.
- States: IDLE, NEG, MUL, FIX, DONE.
- IDLE:
  - START=1 at edge T: capture operands, store sign = A[msb] XOR B[msb], go to NEG.
  - START=0: remain in IDLE.
- NEG (one cycle): magnitude = two's complement (~x+1) of each negative operand, applied in the same cycle; positive operands pass through. Go to MUL, counter=0, accumulator=0.
  - Magnitudes are unsigned WIDTH bits, so -128 yields 0x80 = 128 (no error).
- MUL (one edge per iteration):
  - If multiplier-magnitude LSB=1, add multiplicand magnitude (zero-extended) into the upper half of the 2*WIDTH accumulator.
  - Shift accumulator and multiplier magnitude right by 1; counter++.
  - After WIDTH iterations, go to FIX.
- FIX (one cycle): if sign=1, PRODUCT = two's complement of the accumulator; else PRODUCT = accumulator.
  - OVF = (PRODUCT[2*WIDTH-1:WIDTH-1] is not all-zeros and not all-ones).
  - Go to DONE.
- DONE (one cycle): DONE=1, BUSY=0.
  - START=1 at this edge is accepted (back-to-back operation, go to NEG); otherwise go to IDLE.
  - DONE falls in either case.
- Latency: START sampled at edge T → DONE=1 after edge T+(WIDTH+2), i.e. after edge T+10 for WIDTH=8.
  - BUSY=1 after edges T through T+9, and 0 from edge T+10.
- START while BUSY=1 is ignored (no queuing); operand changes while BUSY have no effect.
- Zero product is never negated to a non-zero value (~0+1 truncates to 0).
- OVF and PRODUCT change only at the FIX→DONE edge, or on reset.

Optional Feature:
Macro SIGNED_MULT_EARLY_TERM_EN.
- Defined: at each MUL edge, if the remaining multiplier magnitude is 0, skip the iteration and go directly to FIX.
  - Latency becomes variable: minimum 3 edges (multiplier 0), maximum WIDTH+2.
  - Results are identical to the non-early-termination build.
- Undefined: fixed latency of WIDTH+2 edges in all cases.

Test Plan:
- Reset (RESET=0) for 2 edges → BUSY=0, DONE=0, PRODUCT=0x0000, OVF=0.
- START, A=5, B=3 → DONE pulses one cycle after edge T+10; PRODUCT=0x000F, OVF=0; BUSY high after edges T..T+9.
- A=-7 (0xF9), B=6 → PRODUCT=0xFFD6 (-42), OVF=0; A=-128 (0x80), B=-128 → PRODUCT=0x4000, OVF=1.
- A=16, B=-8 → PRODUCT=0xFF80, OVF=0; A=16, B=8 → PRODUCT=0x0080, OVF=1.
- START re-asserted mid-operation with A=2, B=2 while computing 5×3 → ignored; result 0x000F. START held high in the DONE cycle → new multiply begins; second DONE 10 edges later.
- RESET=0 at edge T+5 of an operation → IDLE, no DONE, outputs zero.
- With SIGNED_MULT_EARLY_TERM_EN, A=9, B=0 → DONE after edge T+3, PRODUCT=0; B=1 → DONE after edge T+4, PRODUCT=0x0009.
